// File: rtl/rvh_l1d_pkg.sv
// Shared L1D definitions: interface widths, Sv39 PTE field positions and the
// page-table-walker state encoding.
package rvh_l1d_pkg;

  localparam int VPN_WIDTH         = 27;
  localparam int PPN_WIDTH         = 44;
  localparam int PADDR_WIDTH       = 56;
  localparam int PTE_WIDTH         = 64;
  localparam int PTW_ID_WIDTH      = 1;
  localparam int PT_LEVELS         = 3;
  localparam int PAGE_OFFSET_WIDTH = 12;
  localparam int VPN_SEG_WIDTH     = 9;

  // Sv39 PTE field positions
  localparam int PTE_V_BIT   = 0;
  localparam int PTE_R_BIT   = 1;
  localparam int PTE_W_BIT   = 2;
  localparam int PTE_X_BIT   = 3;
  localparam int PTE_PPN_LSB = 10;
  localparam int PTE_PPN_MSB = 53;

  typedef enum logic [1:0] {
    PTW_IDLE,
    PTW_L1D_REQ,
    PTW_WAIT_RESP,
    PTW_TLB_RESP
  } ptw_state_e;

  // VPN slice that indexes the page table at the given level.
  function automatic logic [VPN_SEG_WIDTH-1:0] vpn_seg(input logic [VPN_WIDTH-1:0] vpn,
                                                       input logic [1:0]           level);
    logic [VPN_SEG_WIDTH-1:0] seg;
    case (level)
      2'd0:    seg = vpn[8:0];
      2'd1:    seg = vpn[17:9];
      2'd2:    seg = vpn[26:18];
      default: seg = '0;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/rvh_l1d_ptw_pte_check.sv
// Combinational Sv39 PTE classifier: leaf/fault decision and next-level PPN.
// Shared by the data-side and instruction-side walkers.
module rvh_l1d_ptw_pte_check
  import rvh_l1d_pkg::*;
(
  input  logic [PTE_WIDTH-1:0] pte,
  input  logic [1:0]           level,
  output logic                 leaf,
  output logic                 fault,
  output logic [PPN_WIDTH-1:0] next_ppn
);

  logic pte_v, pte_r, pte_w, pte_x;
  logic unused_pte_bits;

  assign pte_v    = pte[PTE_V_BIT];
  assign pte_r    = pte[PTE_R_BIT];
  assign pte_w    = pte[PTE_W_BIT];
  assign pte_x    = pte[PTE_X_BIT];
  assign next_ppn = pte[PTE_PPN_MSB:PTE_PPN_LSB];

  assign unused_pte_bits = ^{pte[PTE_WIDTH-1:PTE_PPN_MSB+1], pte[PTE_PPN_LSB-1:PTE_X_BIT+1]};

  always_comb begin
    // NOTE: every output is assigned up front so no path through this block
    // leaves a value unassigned, which would otherwise infer a latch.
    leaf  = pte_r | pte_x;
    fault = 1'b0;
    if (!pte_v || (!pte_r && pte_w)) begin
      fault = 1'b1;
    end else if (leaf) begin
      // Superpages must be naturally aligned to their level's page size.
      if (level == 2'd2 && next_ppn[17:0] != '0) fault = 1'b1;
      if (level == 2'd1 && next_ppn[8:0]  != '0) fault = 1'b1;
    end else if (level == 2'd0) begin
      fault = 1'b1;
    end
  end

endmodule

// File: rtl/rvh_l1d_ptw_walker.sv
// Sv39 page-table walker: issues PTE loads into the L1D, walks levels 2..0 and
// hands a leaf PTE or a page fault back to the TLB.
module rvh_l1d_ptw_walker
  import rvh_l1d_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic [PPN_WIDTH-1:0]    satp_ppn_i,
  input  logic                    tlb_ptw_req_vld_i,
  output logic                    tlb_ptw_req_rdy_o,
  input  logic [VPN_WIDTH-1:0]    tlb_ptw_req_vpn_i,
  output logic                    ptw_l1d_req_vld_o,
  input  logic                    ptw_l1d_req_rdy_i,
  output logic [PTW_ID_WIDTH-1:0] ptw_l1d_req_id_o,
  output logic [PADDR_WIDTH-1:0]  ptw_l1d_req_paddr_o,
  input  logic                    l1d_ptw_walk_vld_i,
  input  logic [PTW_ID_WIDTH-1:0] l1d_ptw_walk_id_i,
  input  logic [PTE_WIDTH-1:0]    l1d_ptw_walk_pte_i,
  output logic                    ptw_tlb_resp_vld_o,
  input  logic                    ptw_tlb_resp_rdy_i,
  output logic [VPN_WIDTH-1:0]    ptw_tlb_resp_vpn_o,
  output logic [PTE_WIDTH-1:0]    ptw_tlb_resp_pte_o,
  output logic [1:0]              ptw_tlb_resp_level_o,
  output logic                    ptw_tlb_resp_fault_o
);

  ptw_state_e              state_q, state_d;
  logic [VPN_WIDTH-1:0]    vpn_q;
  logic [PPN_WIDTH-1:0]    cur_ppn_q;
  logic [1:0]              level_q;
  logic [PTW_ID_WIDTH-1:0] walk_id_q;
  logic [PTE_WIDTH-1:0]    resp_pte_q;
  logic [1:0]              resp_level_q;
  logic                    resp_fault_q;

  logic                    pte_leaf, pte_fault;
  logic [PPN_WIDTH-1:0]    pte_next_ppn;
  logic                    req_fire, walk_hit, tlb_fire, walk_done;

  rvh_l1d_ptw_pte_check u_pte_check (
    .pte      (l1d_ptw_walk_pte_i),
    .level    (level_q),
    .leaf     (pte_leaf),
    .fault    (pte_fault),
    .next_ppn (pte_next_ppn)
  );

  assign req_fire  = tlb_ptw_req_vld_i & tlb_ptw_req_rdy_o;
  assign walk_hit  = (state_q == PTW_WAIT_RESP) & l1d_ptw_walk_vld_i &
                     (l1d_ptw_walk_id_i == walk_id_q) & ~flush_i;
  assign walk_done = pte_leaf | pte_fault;
  assign tlb_fire  = (state_q == PTW_TLB_RESP) & ptw_tlb_resp_rdy_i;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = PTW_IDLE;
    end else begin
      case (state_q)
        PTW_IDLE:      if (tlb_ptw_req_vld_i)  state_d = PTW_L1D_REQ;
        PTW_L1D_REQ:   if (ptw_l1d_req_rdy_i)  state_d = PTW_WAIT_RESP;
        PTW_WAIT_RESP: if (walk_hit)           state_d = walk_done ? PTW_TLB_RESP : PTW_L1D_REQ;
        PTW_TLB_RESP:  if (ptw_tlb_resp_rdy_i) state_d = PTW_IDLE;
        default:                               state_d = PTW_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PTW_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpn_q        <= '0;
      cur_ppn_q    <= '0;
      level_q      <= 2'd2;
      walk_id_q    <= '0;
      resp_pte_q   <= '0;
      resp_level_q <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      if (req_fire) begin
        vpn_q     <= tlb_ptw_req_vpn_i;
        cur_ppn_q <= satp_ppn_i;
        level_q   <= 2'd2;
      end
      if (walk_hit) begin
        if (walk_done) begin
          resp_pte_q   <= pte_fault ? '0 : l1d_ptw_walk_pte_i;
          resp_level_q <= level_q;
          resp_fault_q <= pte_fault;
        end else begin
          cur_ppn_q <= pte_next_ppn;
          level_q   <= level_q - 2'd1;
        end
      end
      // A new id on abort orphans any response still in flight from the L1D.
      if ((flush_i && state_q != PTW_IDLE) || tlb_fire) begin
        walk_id_q <= ~walk_id_q;
      end
    end
  end

  // {ppn, 12'b0} + seg*8 never carries out of the page offset, so it is a concat.
  assign ptw_l1d_req_paddr_o = (state_q == PTW_L1D_REQ)
                             ? {cur_ppn_q, vpn_seg(vpn_q, level_q), 3'b000}
                             : '0;

  assign tlb_ptw_req_rdy_o    = (state_q == PTW_IDLE) & ~flush_i;
  assign ptw_l1d_req_vld_o    = (state_q == PTW_L1D_REQ);
  assign ptw_l1d_req_id_o     = walk_id_q;
  assign ptw_tlb_resp_vld_o   = (state_q == PTW_TLB_RESP);
  assign ptw_tlb_resp_vpn_o   = vpn_q;
  assign ptw_tlb_resp_pte_o   = resp_pte_q;
  assign ptw_tlb_resp_level_o = resp_level_q;
  assign ptw_tlb_resp_fault_o = resp_fault_q;

endmodule
